// File: rtl/mul_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Holds the op codes, the FSM states and the counter-width helper.
package mul_div_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULU = 2'b01,
        OP_DIV  = 2'b10,
        OP_DIVU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // The counter must be able to hold WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mul_div_step.sv
// One iteration of the datapath: a shift-add multiply step or a restoring
// divide step, operating on unsigned magnitudes in a 2*WIDTH accumulator.
module mul_div_step #(
    parameter int WIDTH = 32
) (
    input  logic                 i_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_opnd,
    output logic [2*WIDTH-1:0]   o_acc,
    output logic                 o_qbit
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_rem;
    logic             w_ge;

    // Divide: acc = {partial remainder, remaining dividend bits}; the quotient
    // bit goes out on o_qbit and the accumulator LSB is left clear for it.
    always_comb begin
        w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, (i_acc[0] ? i_opnd : {WIDTH{1'b0}})};
        w_ge   = (i_acc[2*WIDTH-1:WIDTH-1] >= {1'b0, i_opnd});
        w_rem  = i_acc[2*WIDTH-2:WIDTH-1] - i_opnd;
        o_qbit = 1'b0;
        o_acc  = '0;
        if (i_div) begin
            o_qbit = w_ge;
            o_acc  = {(w_ge ? w_rem : i_acc[2*WIDTH-2:WIDTH-1]), i_acc[WIDTH-2:0], 1'b0};
        end else begin
            o_acc  = {w_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with start/busy/done handshake.
// Fixed latency: WIDTH iterations plus one sign-fix cycle, then a done pulse.
//
// state   | meaning
// IDLE    | waiting for start
// CALC    | one shift-add / restore-subtract iteration per cycle
// FIX     | sign correction, exception overrides, load results
// DONE    | done pulse; a start here is accepted back-to-back
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_e             r_state;
    logic               r_div;
    logic               r_neg_main;
    logic               r_neg_rem;
    logic               r_b_zero;
    logic [WIDTH-1:0]   r_a_orig;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;

    logic               w_is_div;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // Two's-complement negation of the most negative value yields 2^(WIDTH-1) unsigned.
    always_comb begin
        w_is_div = (op == OP_DIV) || (op == OP_DIVU);
        w_neg_a  = ((op == OP_MUL) || (op == OP_DIV)) && operand_a[WIDTH-1];
        w_neg_b  = ((op == OP_MUL) || (op == OP_DIV)) && operand_b[WIDTH-1];
        w_mag_a  = w_neg_a ? -operand_a : operand_a;
        w_mag_b  = w_neg_b ? -operand_b : operand_b;
        w_prod   = r_neg_main ? -r_acc : r_acc;
        w_quot   = r_neg_main ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem    = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end

    mul_div_step #(.WIDTH(WIDTH)) u_step (
        .i_div  (r_div),
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .o_acc  (w_acc_next),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_div       <= 1'b0;
            r_neg_main  <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_b_zero    <= 1'b0;
            r_a_orig    <= '0;
            r_opnd      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_div      <= w_is_div;
                        r_neg_main <= w_neg_a ^ w_neg_b;
                        r_neg_rem  <= w_neg_a;
                        r_b_zero   <= (operand_b == '0);
                        r_a_orig   <= operand_a;
                        r_acc      <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                        r_opnd     <= w_is_div ? w_mag_b : w_mag_a;
                        r_cnt      <= '0;
                        busy       <= 1'b1;
                        r_state    <= ST_CALC;
                    end else begin
                        r_state    <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    r_acc <= w_acc_next | {{(2*WIDTH-1){1'b0}}, w_qbit};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_ITER) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    // MIN/-1 needs no override: magnitude 2^(WIDTH-1) already wraps to MIN.
                    if (r_div && r_b_zero) begin
                        result_lo   <= '1;
                        result_hi   <= r_a_orig;
                        div_by_zero <= 1'b1;
                    end else if (r_div) begin
                        result_lo   <= w_quot;
                        result_hi   <= w_rem;
                        div_by_zero <= 1'b0;
                    end else begin
                        result_lo   <= w_prod[WIDTH-1:0];
                        result_hi   <= w_prod[2*WIDTH-1:WIDTH];
                        div_by_zero <= 1'b0;
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
